// File: rtl/pool_result_collector_pkg.sv
// Shared definitions for the pooled-result collector: default geometry and FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pool_result_collector_pkg;

    localparam int DATA_W_DEF = 23;   // width of one pooled result
    localparam int N_OUT_DEF  = 9;    // results per 3x3 pooled tile
    localparam int ADDR_W_DEF = 4;    // width of the slot index
    localparam int OUT_W_DEF  = 8;    // clamp width when output saturation is built in

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pool_slot_regfile.sv
// Slot storage for one pooled tile: N_OUT x DATA_W registers, one write port, one async read port, fill mask.
// Latency: a write is visible on rd_data the cycle after it is presented; full_nxt is combinational.
// Backpressure: none; the caller gates wr_en. Ports: clk/rst, clr (frame clear), wr_*, rd_addr/rd_data, full_nxt.
module pool_slot_regfile
    import pool_result_collector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              full_nxt
);

    logic [DATA_W-1:0] slot_q [N_OUT];
    logic [DATA_W-1:0] slot_d [N_OUT];
    logic [N_OUT-1:0]  mask_q;
    logic [N_OUT-1:0]  mask_d;

    // Clear happens before the write so a write coinciding with clr lands in the new frame.
    // The mask is a set of bits, so repeated writes to one slot can never count twice.
    always_comb begin
        slot_d = slot_q;
        mask_d = clr ? '0 : mask_q;
        if (wr_en) begin
            slot_d[wr_addr] = wr_data;
            mask_d[wr_addr] = 1'b1;
        end
    end

    // Look-ahead full flag lets the FSM enter DRAIN on the edge of the final write.
    assign full_nxt = &mask_d;
    assign rd_data  = slot_q[rd_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            mask_q <= mask_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/pool_result_collector.sv
// Collects the N_OUT pooled results of one tile in any order, then streams them out in index order.
// Latency: first m_valid one cycle after the final slot write; then up to one word per cycle.
// Backpressure: m_ready low holds m_data/m_index/m_last stable. Optional clamp: define POOL_OUT_SAT_EN.
// Ports: clk, rst (async active-low), frame_start, wr_en/wr_addr/wr_data (processor side),
//        m_valid/m_ready/m_data/m_index/m_last (stream side), done, err_range, err_late (sticky flags).
module pool_result_collector
    import pool_result_collector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef POOL_OUT_SAT_EN
    , parameter int OUT_W = OUT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic              done,
    output logic              err_range,
    output logic              err_late
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] m_index_q, m_index_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic              err_range_q, err_range_d;
    logic              err_late_q, err_late_d;

    logic              in_collect;
    logic              addr_ok;
    logic              slot_we;
    logic              full_nxt;
    logic              hs;
    logic              repeat_wr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;

    // frame_start makes this cycle behave as COLLECT so a simultaneous write joins the new frame.
    assign in_collect = frame_start || (state_q == ST_COLLECT);
    assign addr_ok    = (wr_addr <= LAST_IDX);
    assign slot_we    = wr_en && addr_ok && in_collect;
    assign hs         = (state_q == ST_DRAIN) && m_ready;
    // A processor holding write_out high keeps repeating its last write; that is not a late write.
    assign repeat_wr  = (wr_addr == last_addr_q) && (wr_data == last_data_q);

    pool_slot_regfile #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_start),
        .wr_en    (slot_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (m_index_q),
        .rd_data  (rd_data),
        .full_nxt (full_nxt)
    );

    always_comb begin
        state_d     = state_q;
        m_index_d   = m_index_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        err_range_d = err_range_q;
        err_late_d  = err_late_q;

        if (frame_start) begin
            state_d     = ST_COLLECT;
            m_index_d   = '0;
            err_range_d = 1'b0;
            err_late_d  = 1'b0;
        end

        if (in_collect && wr_en) begin
            if (addr_ok) begin
                last_addr_d = wr_addr;
                last_data_d = wr_data;
            end else begin
                err_range_d = 1'b1;
            end
            if (slot_we && full_nxt) begin
                state_d = ST_DRAIN;
            end
        end

        if (!in_collect && wr_en && !repeat_wr) begin
            err_late_d = 1'b1;
        end

        // m_index parks on the last slot after the final beat; frame_start rewinds it.
        if (!frame_start && hs) begin
            if (m_index_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                m_index_d = m_index_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_COLLECT;
            m_index_q   <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            err_range_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_index_q   <= m_index_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            err_range_q <= err_range_d;
            err_late_q  <= err_late_d;
        end
    end

`ifdef POOL_OUT_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'((2 ** OUT_W) - 1);
    assign out_data = (rd_data > SAT_MAX) ? SAT_MAX : rd_data;
`else
    assign out_data = rd_data;
`endif

    assign m_valid   = (state_q == ST_DRAIN);
    assign m_data    = m_valid ? out_data : '0;
    assign m_index   = m_index_q;
    assign m_last    = m_valid && (m_index_q == LAST_IDX);
    assign done      = (state_q == ST_DONE);
    assign err_range = err_range_q;
    assign err_late  = err_late_q;

endmodule

// File: tb/tb_pool_result_collector.sv
// Directed bench for pool_result_collector: fill patterns, ordering, stalls, errors, reset, clamp.
// Latency: n/a.
// Backpressure: m_ready is driven per scenario.
module tb_pool_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [22:0] wr_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [22:0] m_data;
    logic [3:0]  m_index;
    logic        m_last;
    logic        done;
    logic        err_range;
    logic        err_late;

    int n_cmp = 0;
    int n_err = 0;

    logic [22:0] cap_data [$];
    logic [3:0]  cap_idx  [$];
    logic        cap_last [$];

    pool_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .done        (done),
        .err_range   (err_range),
        .err_late    (err_late)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change 1 time unit after a rising edge, outputs are sampled there too.
    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic write_slot(input logic [3:0] a, input logic [22:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget, output bit timed_out);
        cap_data.delete(); cap_idx.delete(); cap_last.delete();
        m_ready = 1'b1;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin timed_out = 1'b0; break; end
            if (m_valid) begin
                cap_data.push_back(m_data); cap_idx.push_back(m_index); cap_last.push_back(m_last);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_index !== 4'd0) begin n_err++; $display("FAIL reset_m_index: got %0d want 0", m_index); end
        n_cmp++; if (m_data !== 23'd0) begin n_err++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
        n_cmp++; if ({m_last, done, err_range, err_late} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {m_last, done, err_range, err_late});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_in_order();
        bit to;
        pulse_frame_start();
        for (int i = 0; i < 8; i++) write_slot(4'(i), 23'(10 + i));
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL inorder_early_valid: got %b want 0", m_valid); end
        write_slot(4'd8, 23'd18);
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL inorder_latency: got %b want 1", m_valid); end
        drain(40, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL inorder_timeout: got %b want 0", to); end
        n_cmp++; if (cap_data.size() != 9) begin n_err++; $display("FAIL inorder_beats: got %0d want 9", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 9; i++) begin
            n_cmp++;
            if (cap_data[i] !== 23'(10 + i) || cap_idx[i] !== 4'(i) || cap_last[i] !== (i == 8)) begin
                n_err++;
                $display("FAIL inorder_beat%0d: got data %0d idx %0d last %b want data %0d idx %0d last %b",
                         i, cap_data[i], cap_idx[i], cap_last[i], 10 + i, i, (i == 8));
            end
        end
        @(posedge clk); #1;
        n_cmp++; if ({done, m_valid} !== 2'b10) begin n_err++; $display("FAIL inorder_done: got done,valid %b want 10", {done, m_valid}); end
    endtask

    task automatic test_out_of_order();
        bit to;
        int order [9] = '{8, 3, 0, 5, 1, 7, 2, 6, 4};
        pulse_frame_start();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ooo_done_clear: got %b want 0", done); end
        for (int i = 0; i < 8; i++) write_slot(4'(order[i]), 23'(100 + order[i]));
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL ooo_early_valid: got %b want 0", m_valid); end
        write_slot(4'd4, 23'd104);
        n_cmp++; if (m_valid !== 1'b1 || m_index !== 4'd0) begin
            n_err++; $display("FAIL ooo_latency: got valid %b idx %0d want 1 0", m_valid, m_index);
        end
        drain(40, to);
        n_cmp++; if (to !== 1'b0 || cap_data.size() != 9) begin
            n_err++; $display("FAIL ooo_beats: got %0d timeout %b want 9 0", cap_data.size(), to);
        end
        for (int i = 0; i < cap_data.size() && i < 9; i++) begin
            n_cmp++;
            if (cap_data[i] !== 23'(100 + i) || cap_idx[i] !== 4'(i)) begin
                n_err++; $display("FAIL ooo_beat%0d: got %0d@%0d want %0d@%0d", i, cap_data[i], cap_idx[i], 100 + i, i);
            end
        end
    endtask

    task automatic test_sticky_write();
        bit to;
        int others [7] = '{0, 1, 3, 4, 5, 6, 7};
        pulse_frame_start();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 23'h7FFFFF;
        repeat (5) begin @(posedge clk); #1; end
        wr_en = 1'b0;
        n_cmp++; if ({m_valid, err_range, err_late} !== 3'b000) begin
            n_err++; $display("FAIL sticky_hold: got valid,range,late %b want 000", {m_valid, err_range, err_late});
        end
        for (int i = 0; i < 7; i++) write_slot(4'(others[i]), 23'(256 + others[i]));
        write_slot(4'd2, 23'd1);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL sticky_count: got valid %b want 0", m_valid); end
        // Final write held high through the whole drain, as a sticky write_out would.
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 23'h88;
        @(posedge clk); #1;
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL sticky_complete: got %b want 1", m_valid); end
        drain(40, to);
        wr_en = 1'b0;
        n_cmp++; if (to !== 1'b0 || cap_data.size() != 9) begin
            n_err++; $display("FAIL sticky_beats: got %0d timeout %b want 9 0", cap_data.size(), to);
        end
        if (cap_data.size() == 9) begin
            n_cmp++; if (cap_data[2] !== 23'd1) begin n_err++; $display("FAIL sticky_rewrite: got %0h want 1", cap_data[2]); end
            n_cmp++; if (cap_data[8] !== 23'h88 || cap_data[0] !== 23'd256) begin
                n_err++; $display("FAIL sticky_data: got %0h %0h want 100 88", cap_data[0], cap_data[8]);
            end
        end
        n_cmp++; if ({err_range, err_late} !== 2'b00) begin
            n_err++; $display("FAIL sticky_no_err: got range,late %b want 00", {err_range, err_late});
        end
    endtask

    task automatic test_backpressure();
        bit [3:0] pat = 4'b1001;   // bit c%4 gives m_ready for cycle c: 1,0,0,1,...
        int exp_idx = 0;
        pulse_frame_start();
        for (int i = 0; i < 9; i++) write_slot(4'(i), 23'(50 + i));
        for (int c = 0; c < 60 && exp_idx < 9; c++) begin
            m_ready = pat[c % 4];
            n_cmp++;
            if (m_valid !== 1'b1 || m_index !== 4'(exp_idx) || m_data !== 23'(50 + exp_idx)) begin
                n_err++;
                $display("FAIL bp_cycle%0d: got valid %b idx %0d data %0d want 1 %0d %0d",
                         c, m_valid, m_index, m_data, exp_idx, 50 + exp_idx);
            end
            if (m_ready) exp_idx++;
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        n_cmp++; if (exp_idx != 9 || done !== 1'b1 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_end: got beats %0d done %b valid %b want 9 1 0", exp_idx, done, m_valid);
        end
    endtask

    task automatic test_errors();
        pulse_frame_start();
        write_slot(4'd9, 23'd5);
        n_cmp++; if ({err_range, err_late} !== 2'b10) begin
            n_err++; $display("FAIL err_range_set: got range,late %b want 10", {err_range, err_late});
        end
        for (int i = 0; i < 8; i++) write_slot(4'(i), 23'(i));
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL err_mask_unchanged: got valid %b want 0", m_valid); end
        write_slot(4'd8, 23'd8);
        write_slot(4'd3, 23'h123);
        n_cmp++; if ({err_range, err_late} !== 2'b11) begin
            n_err++; $display("FAIL err_late_set: got range,late %b want 11", {err_range, err_late});
        end
        n_cmp++; if (m_valid !== 1'b1 || m_index !== 4'd0 || m_data !== 23'd0) begin
            n_err++; $display("FAIL err_late_ignored: got valid %b idx %0d data %0h want 1 0 0", m_valid, m_index, m_data);
        end
        pulse_frame_start();
        n_cmp++; if ({err_range, err_late, m_valid} !== 3'b000) begin
            n_err++; $display("FAIL err_clear: got range,late,valid %b want 000", {err_range, err_late, m_valid});
        end
    endtask

    task automatic test_frame_start_write();
        bit to;
        pulse_frame_start();
        for (int i = 0; i < 5; i++) write_slot(4'(i), 23'd999);
        // New frame begins with a write in the same cycle: only that write survives the clear.
        frame_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 23'd77;
        @(posedge clk); #1;
        frame_start = 1'b0; wr_en = 1'b0;
        for (int i = 1; i < 8; i++) write_slot(4'(i), 23'(70 + i));
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fsw_early_valid: got %b want 0", m_valid); end
        write_slot(4'd8, 23'd78);
        drain(40, to);
        n_cmp++; if (to !== 1'b0 || cap_data.size() != 9 || cap_data[0] !== 23'd77 || cap_data[4] !== 23'd74) begin
            n_err++; $display("FAIL fsw_data: got beats %0d first %0d want 9 77", cap_data.size(),
                              (cap_data.size() > 0) ? cap_data[0] : 23'd0);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        bit hit = 1'b0;
        pulse_frame_start();
        for (int i = 0; i < 9; i++) write_slot(4'(i), 23'(20 + i));
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (m_index == 4'd4) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        n_cmp++; if (hit !== 1'b1 || m_data !== 23'd24) begin
            n_err++; $display("FAIL rmd_reach4: got reached %b data %0d want 1 24", hit, m_data);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if ({m_valid, m_last, done} !== 3'b000 || m_index !== 4'd0 || m_data !== 23'd0) begin
            n_err++; $display("FAIL rmd_outputs: got valid %b idx %0d data %0h want 0 0 0", m_valid, m_index, m_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (m_valid !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rmd_no_partial: got valid %b done %b want 0 0", m_valid, done);
        end
        for (int i = 0; i < 9; i++) write_slot(4'(i), 23'(30 + i));
        drain(40, to);
        n_cmp++; if (to !== 1'b0 || cap_data.size() != 9 || cap_data[0] !== 23'd30 || cap_data[8] !== 23'd38) begin
            n_err++; $display("FAIL rmd_restart: got beats %0d timeout %b want 9 0", cap_data.size(), to);
        end
    endtask

    task automatic test_saturation();
        bit to;
        logic [22:0] exp0;
`ifdef POOL_OUT_SAT_EN
        exp0 = 23'd255;
`else
        exp0 = 23'd300;
`endif
        pulse_frame_start();
        write_slot(4'd0, 23'd300);
        write_slot(4'd1, 23'd200);
        for (int i = 2; i < 9; i++) write_slot(4'(i), 23'(i));
        drain(40, to);
        n_cmp++; if (to !== 1'b0 || cap_data.size() != 9) begin
            n_err++; $display("FAIL sat_beats: got %0d timeout %b want 9 0", cap_data.size(), to);
        end
        if (cap_data.size() == 9) begin
            n_cmp++; if (cap_data[0] !== exp0) begin n_err++; $display("FAIL sat_300: got %0d want %0d", cap_data[0], exp0); end
            n_cmp++; if (cap_data[1] !== 23'd200) begin n_err++; $display("FAIL sat_200: got %0d want 200", cap_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_sticky_write();
        test_backpressure();
        test_errors();
        test_frame_start_write();
        test_reset_mid_drain();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
